// File: rtl/audio_sample_reader_if.sv
// Codec-read and sample-stream signals of audio_sample_reader.
// master: the reader (pops the codec, drives the stream).
// slave:  the environment (codec model plus downstream DSP consumer).
// Handshakes:
//   codec side  - when read_ready=1 the codec offers readdata_left/right; the
//                 reader samples them and answers with a one-cycle read pulse.
//   stream side - the head is transferred on every clock edge where
//                 out_valid=1 and out_ready=1; out_left/out_right are stable
//                 while out_valid=1 and out_ready=0.
interface audio_sample_reader_if #(
  parameter int DATA_W = 24
);
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;

  modport master (
    input  read_ready, readdata_left, readdata_right, out_ready,
    output read, out_valid, out_left, out_right
  );

  modport slave (
    output read_ready, readdata_left, readdata_right, out_ready,
    input  read, out_valid, out_left, out_right
  );
endinterface

// File: rtl/audio_sample_reader.sv
// audio_sample_reader: drains left/right sample pairs from the codec read
// port, buffers them in a small first-word-fall-through FIFO and streams them
// to downstream DSP logic. Also counts codec samples lost while the FIFO was
// full (saturating) and tracks the left-channel peak level for LED metering.
// Optional build macro MONO_MIX_EN: when defined, each pushed pair is replaced
// by the arithmetic mean of left and right in both fields.
module audio_sample_reader #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 3,
  parameter int OVR_W      = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    enable,
  audio_sample_reader_if.master   bus,
  output logic [DEPTH_LOG2:0]     fill_level,
  output logic [OVR_W-1:0]        overrun_count,
  output logic [7:0]              peak_level,
  input  logic                    peak_clear,
  output logic [1:0]              state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                read_q, read_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    fill_q, fill_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;
  logic [7:0]          peak_q, peak_d;
  logic                rr_q, rr_d;
  logic [DATA_W-1:0]   last_left_q, last_left_d;
  logic [DATA_W-1:0]   last_right_q, last_right_d;
  logic [DATA_W-1:0]   mem_left_q  [DEPTH];
  logic [DATA_W-1:0]   mem_right_q [DEPTH];

  logic                full, empty;
  logic                start, push, pop;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0]   wr_left, wr_right;
  logic [DATA_W-1:0]   head_left, head_right;
  logic [DATA_W-1:0]   cap_left;
  logic [7:0]          peak_sample;

  // Pointer-derived status; full when pointers differ only in the wrap bit.
  always_comb begin
    wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
    rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
    start  = (state_q == IDLE) && enable && bus.read_ready && !full;
    push   = (state_q == CAPTURE);
    pop    = !empty && bus.out_ready;
  end

`ifdef MONO_MIX_EN
  logic [DATA_W:0] mix_sum;

  // Sign-extended sum, halved by taking the upper DATA_W bits (>>> 1).
  always_comb begin
    mix_sum  = {bus.readdata_left[DATA_W-1], bus.readdata_left}
             + {bus.readdata_right[DATA_W-1], bus.readdata_right};
    wr_left  = mix_sum[DATA_W:1];
    wr_right = mix_sum[DATA_W:1];
  end
`else
  // Channels are stored exactly as the codec delivers them.
  always_comb begin
    wr_left  = bus.readdata_left;
    wr_right = bus.readdata_right;
  end
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state: one capture takes exactly three clocks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CAPTURE;
      CAPTURE: state_d = HOLDOFF;
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read is registered so it is high during CAPTURE only.
  always_comb begin
    read_d = start;
  end

  // Sample the codec data into the write slot on the edge entering CAPTURE.
  always_ff @(posedge clock) begin
    if (start) begin
      mem_left_q[wr_idx]  <= wr_left;
      mem_right_q[wr_idx] <= wr_right;
    end
  end

  // Peak magnitude of the slot being committed, bits [DATA_W-2:DATA_W-9] of
  // |left|. For negative x the upper bits of -x are ~x plus a carry that only
  // arrives when every lower bit is zero; the most-negative value saturates.
  always_comb begin
    cap_left = mem_left_q[wr_idx];
    if (!cap_left[DATA_W-1]) begin
      peak_sample = cap_left[DATA_W-2:DATA_W-9];
    end else if (cap_left[DATA_W-2:0] == '0) begin
      peak_sample = 8'hFF;
    end else if (cap_left[DATA_W-10:0] == '0) begin
      peak_sample = ~cap_left[DATA_W-2:DATA_W-9] + 8'd1;
    end else begin
      peak_sample = ~cap_left[DATA_W-2:DATA_W-9];
    end
  end

  // Next-state for pointers, fill count, overrun counter, peak and held output.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    ovr_d        = ovr_q;
    peak_d       = peak_q;
    rr_d         = bus.read_ready;
    last_left_d  = last_left_q;
    last_right_d = last_right_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      last_left_d  = head_left;
      last_right_d = head_right;
    end

    case ({push, pop})
      2'b10:   fill_d = fill_q + PTR_W'(1);
      2'b01:   fill_d = fill_q - PTR_W'(1);
      default: fill_d = fill_q;
    endcase

    // One count per codec sample: rising read_ready seen while full.
    if (enable && full && bus.read_ready && !rr_q && (ovr_q != '1))
      ovr_d = ovr_q + OVR_W'(1);

    if (peak_clear)
      peak_d = 8'h00;
    else if (push && (peak_sample > peak_q))
      peak_d = peak_sample;
  end

  // Datapath registers; FIFO contents are discarded by resetting pointers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      read_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      ovr_q        <= '0;
      peak_q       <= '0;
      rr_q         <= 1'b0;
      last_left_q  <= '0;
      last_right_q <= '0;
    end else begin
      read_q       <= read_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      ovr_q        <= ovr_d;
      peak_q       <= peak_d;
      rr_q         <= rr_d;
      last_left_q  <= last_left_d;
      last_right_q <= last_right_d;
    end
  end

  // First-word-fall-through head; holds the last popped pair when empty.
  always_comb begin
    head_left     = mem_left_q[rd_idx];
    head_right    = mem_right_q[rd_idx];
    bus.out_valid = !empty;
    bus.out_left  = empty ? last_left_q  : head_left;
    bus.out_right = empty ? last_right_q : head_right;
  end

  assign bus.read      = read_q;
  assign fill_level    = fill_q;
  assign overrun_count = ovr_q;
  assign peak_level    = peak_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_audio_sample_reader.sv
// Directed testbench for audio_sample_reader: codec driver, stream scoreboard
// and peak/overrun checks with hand-computed expected values.
module tb_audio_sample_reader;
  localparam int DATA_W     = 24;
  localparam int DEPTH_LOG2 = 3;
  localparam int OVR_W      = 8;

  logic                  clock = 1'b0;
  logic                  resetn = 1'b0;
  logic                  enable = 1'b0;
  logic                  peak_clear = 1'b0;
  logic [DEPTH_LOG2:0]   fill_level;
  logic [OVR_W-1:0]      overrun_count;
  logic [7:0]            peak_level;
  logic [1:0]            state_dbg;

  audio_sample_reader_if #(.DATA_W(DATA_W)) bus ();

  audio_sample_reader #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .OVR_W(OVR_W)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .enable(enable),
    .bus(bus),
    .fill_level(fill_level),
    .overrun_count(overrun_count),
    .peak_level(peak_level),
    .peak_clear(peak_clear),
    .state_dbg(state_dbg)
  );

  // Clock / reset block.
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    exp_q.delete();
  endtask

  // Expected stored pair for a codec pair.
  function automatic logic [2*DATA_W-1:0] exp_pair(input logic [DATA_W-1:0] l,
                                                    input logic [DATA_W-1:0] r);
`ifdef MONO_MIX_EN
    logic [DATA_W:0] s;
    s = {l[DATA_W-1], l} + {r[DATA_W-1], r};
    return {s[DATA_W:1], s[DATA_W:1]};
`else
    return {l, r};
`endif
  endfunction

  // Codec driver: offer one pair, wait (bounded) for read, then drop
  // read_ready. clr raises peak_clear during the commit cycle.
  task automatic codec_send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input logic clr);
    logic seen;
    seen = 1'b0;
    bus.readdata_left  = l;
    bus.readdata_right = r;
    bus.read_ready     = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.read) seen = 1'b1;
    end
    check("read_seen", {31'd0, seen}, 32'd1);
    bus.read_ready = 1'b0;
    peak_clear     = clr;
    tick();
    peak_clear = 1'b0;
    tick();
    if (seen) exp_q.push_back(exp_pair(l, r));
  endtask

  // Codec offers a sample while the FIFO is full; no read may be issued.
  task automatic codec_offer();
    bus.read_ready = 1'b1;
    tick();
    check("no_read_full", {31'd0, bus.read}, 32'd0);
    tick();
    check("no_read_full", {31'd0, bus.read}, 32'd0);
    bus.read_ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [2*DATA_W-1:0] e;
    logic [2*DATA_W-1:0] last_e;
    logic seen;

    bus.read_ready     = 1'b0;
    bus.readdata_left  = '0;
    bus.readdata_right = '0;
    bus.out_ready      = 1'b0;
    last_e = '0;

    // Reset state.
    do_reset();
    check("rst_read", {31'd0, bus.read}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_left", {8'd0, bus.out_left}, 32'd0);
    check("rst_right", {8'd0, bus.out_right}, 32'd0);
    check("rst_fill", {28'd0, fill_level}, 32'd0);
    check("rst_ovr", {24'd0, overrun_count}, 32'd0);
    check("rst_peak", {24'd0, peak_level}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // read_ready held: read pulses every third cycle.
    enable = 1'b1;
    bus.readdata_left  = 24'h100000;
    bus.readdata_right = 24'h0FFFFF;
    bus.read_ready     = 1'b1;
    e = exp_pair(24'h100000, 24'h0FFFFF);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("read_cadence", {31'd0, bus.read}, (i % 3 == 1) ? 32'd1 : 32'd0);
      if (i == 2) begin
        check("first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("first_left", {8'd0, bus.out_left}, {8'd0, e[2*DATA_W-1:DATA_W]});
        check("first_right", {8'd0, bus.out_right}, {8'd0, e[DATA_W-1:0]});
        check("first_fill", {28'd0, fill_level}, 32'd1);
      end
    end
    bus.read_ready = 1'b0;
    tick();
    check("three_fill", {28'd0, fill_level}, 32'd3);

    // Fill the FIFO with 1..8, then three samples arrive while full.
    do_reset();
    for (int k = 1; k <= 8; k++) codec_send(DATA_W'(k), DATA_W'(k + 256), 1'b0);
    check("full_fill", {28'd0, fill_level}, 32'd8);
    for (int k = 0; k < 3; k++) codec_offer();
    check("ovr_count", {24'd0, overrun_count}, 32'd3);
    check("full_fill_hold", {28'd0, fill_level}, 32'd8);

    // One pop while read_ready=1, then the refill push of sample 9.
    bus.readdata_left  = DATA_W'(9);
    bus.readdata_right = DATA_W'(9 + 256);
    bus.read_ready     = 1'b1;
    bus.out_ready      = 1'b1;
    e = exp_q.pop_front();
    check("pop_left", {8'd0, bus.out_left}, {8'd0, e[2*DATA_W-1:DATA_W]});
    check("pop_right", {8'd0, bus.out_right}, {8'd0, e[DATA_W-1:0]});
    tick();
    bus.out_ready = 1'b0;
    check("after_pop_fill", {28'd0, fill_level}, 32'd7);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      if (bus.read) seen = 1'b1;
    end
    check("refill_read", {31'd0, seen}, 32'd1);
    bus.read_ready = 1'b0;
    exp_q.push_back(exp_pair(DATA_W'(9), DATA_W'(9 + 256)));
    tick();
    check("refill_fill", {28'd0, fill_level}, 32'd8);

    // Drain and check order 2..9 against the scoreboard.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      last_e = e;
      check("drain_valid", {31'd0, bus.out_valid}, 32'd1);
      check("drain_left", {8'd0, bus.out_left}, {8'd0, e[2*DATA_W-1:DATA_W]});
      check("drain_right", {8'd0, bus.out_right}, {8'd0, e[DATA_W-1:0]});
      tick();
    end
    bus.out_ready = 1'b0;
    check("drain_empty", {31'd0, bus.out_valid}, 32'd0);
    check("drain_fill", {28'd0, fill_level}, 32'd0);
    check("hold_left", {8'd0, bus.out_left}, {8'd0, last_e[2*DATA_W-1:DATA_W]});
    check("hold_right", {8'd0, bus.out_right}, {8'd0, last_e[DATA_W-1:0]});

    // Reset during the CAPTURE cycle.
    codec_send(24'h000123, 24'h000456, 1'b0);
    check("pre_rst_fill", {28'd0, fill_level}, 32'd1);
    bus.read_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.read) seen = 1'b1;
    end
    check("mid_read", {31'd0, seen}, 32'd1);
    resetn = 1'b0;
    tick();
    check("mid_rst_read", {31'd0, bus.read}, 32'd0);
    check("mid_rst_fill", {28'd0, fill_level}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_ovr", {24'd0, overrun_count}, 32'd0);
    bus.read_ready = 1'b0;
    resetn = 1'b1;
    exp_q.delete();
    tick();

    // Peak metering (right = left so mono mixing leaves the value unchanged).
    do_reset();
    bus.out_ready = 1'b1;
    codec_send(24'h200000, 24'h200000, 1'b0);
    check("peak_40", {24'd0, peak_level}, 32'h40);
    codec_send(24'hC00000, 24'hC00000, 1'b0);
    check("peak_80", {24'd0, peak_level}, 32'h80);
    codec_send(24'h800000, 24'h800000, 1'b0);
    check("peak_ff", {24'd0, peak_level}, 32'hFF);
    codec_send(24'h100000, 24'h100000, 1'b0);
    check("peak_keep", {24'd0, peak_level}, 32'hFF);
    codec_send(24'h7FFFFF, 24'h7FFFFF, 1'b1);
    check("peak_clear", {24'd0, peak_level}, 32'h00);
    bus.out_ready = 1'b0;

    // Channel mixing.
    do_reset();
    codec_send(24'h000010, 24'hFFFFF0, 1'b0);
    codec_send(24'h000006, 24'h000002, 1'b0);
`ifdef MONO_MIX_EN
    check("mix0_left", {8'd0, bus.out_left}, 32'h000000);
    check("mix0_right", {8'd0, bus.out_right}, 32'h000000);
`else
    check("pass0_left", {8'd0, bus.out_left}, 32'h000010);
    check("pass0_right", {8'd0, bus.out_right}, 32'hFFFFF0);
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
`ifdef MONO_MIX_EN
    check("mix1_left", {8'd0, bus.out_left}, 32'h000004);
    check("mix1_right", {8'd0, bus.out_right}, 32'h000004);
`else
    check("pass1_left", {8'd0, bus.out_left}, 32'h000006);
    check("pass1_right", {8'd0, bus.out_right}, 32'h000002);
`endif
    check("mix_fill", {28'd0, fill_level}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
